operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Upstream operand-entry stage for the ALU/display datapath on the FPGA board. Replaces the hard-wired operands.
- The user sets 4 slide switches and presses one push button to latch A, then B, then the ALU select code, in that order.
- Registered a, b and sel then drive the ALU directly; valid flags a complete operand set.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles the button level must hold before it is accepted; minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width; derived, do not override.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- sw  input  4  slide switches; operand/select value being entered.
- btn  input  1  load push button, active-high, raw and bouncy.
- a  output  4  signed operand A to ALU.
- b  output  4  signed operand B to ALU.
- sel  output  4  ALU select code; sel[3] also drives the display decoder.
- valid  output  1  high while a, b and sel form a complete loaded set.
- stage  output  2  current FSM state encoding, for LED indication.

Behaviour:
- Reset (rst_n low at a rising edge): a=0, b=0, sel=0, valid=0, stage=LOAD_A (2'd0), debounce counter=0, stable button level=0, press pulse=0.
- Debounce:
  - Sampled button level is compared against the stable level each cycle.
  - If they are equal, the counter clears.
  - If they differ, the counter increments. When it reaches DEBOUNCE_CYCLES-1 with the levels still differing, the stable level takes the sampled value and the counter clears.
  - Net effect: a level held for exactly DEBOUNCE_CYCLES sampled cycles is accepted. Any shorter pulse or glitch has no effect.
- Press pulse:
  - Registered, one cycle wide, on a 0->1 transition of the stable level only.
  - The release (1->0) transition is debounced identically but produces no pulse.
  - Holding the button produces exactly one pulse.
- FSM states: LOAD_A=0, LOAD_B=1, LOAD_SEL=2, RUN=3. Transitions occur only on a press pulse; with no pulse, the state and all outputs hold.
  - LOAD_A + press: a<=sw; go to LOAD_B.
  - LOAD_B + press: b<=sw; go to LOAD_SEL.
  - LOAD_SEL + press: sel<=sw; valid<=1; go to RUN.
  - RUN + press: valid<=0; go to LOAD_A. Previous a, b and sel are retained until overwritten.
- Latency: outputs update at the edge on which the press pulse is high. Without the sync option, that is edge DEBOUNCE_CYCLES+1 after btn first reads high.
- Switch handling: sw is captured only at the load edge; sw changes at any other time are ignored. a and b are raw two's-complement nibbles with no range checking.
- Reset mid-operation:
  - Everything returns to reset values, including mid-debounce state; any partially entered set is discarded.
  - A button held through reset counts as a new press: it is accepted DEBOUNCE_CYCLES cycles after reset deasserts.
- stage always equals the current state encoding.

Optional Feature:
- Macro: OPERAND_LOADER_SYNC_EN.
- Defined:
  - btn and sw each pass through a 2-flop synchronizer, reset to 0, before any other logic uses them.
  - Press latency grows by 2 cycles.
  - sw is captured from its synchronized copy.
- Undefined:
  - btn and sw are used directly as the sampled values.
  - For use only with an external synchronizer or in simulation.

Test Plan:
- Sequential load: DEBOUNCE_CYCLES=4, no sync. After reset: sw=0111 + clean press; sw=1010 + press; sw=0011 + press -> a=0111, b=1010, sel=0011, valid=1, stage=3. Each update occurs 5 edges after btn rises.
- Bounce rejection: btn toggles high/low every 1-3 cycles for 20 cycles, then settles low -> no pulse, stage remains 0, outputs remain 0.
- Held button: btn high for 50 cycles in LOAD_A -> exactly one transition (stage 0->1). Release followed by re-press -> stage 2.
- Rearm: in RUN with the full set loaded, press -> valid=0, stage=0, a/b/sel unchanged. Next press with sw=1111 -> a=1111.
- Mid-sequence reset: in LOAD_SEL with a=0101, assert rst_n=0 for 1 cycle -> a=b=sel=0, valid=0, stage=0.
- Sync option: define OPERAND_LOADER_SYNC_EN and repeat the first scenario -> identical final values, each update 7 edges after btn rises.

Source files
------------

// File: rtl/operand_loader.sv
// operand_loader
//   Operand-entry stage for the ALU/display datapath. The user sets four slide
//   switches and presses a single load button three times to latch operand A,
//   operand B and the ALU select code, in that order. Once all three are held,
//   valid is raised. A fourth press drops valid and rearms the sequence; the
//   previous a/b/sel values remain visible until each is overwritten.
//
//   Ports:
//     clk    in   1  system clock, rising edge
//     rst_n  in   1  synchronous reset, active low
//     sw     in   4  slide switches (value being entered)
//     btn    in   1  load push button, active high, raw/bouncy
//     a      out  4  signed operand A
//     b      out  4  signed operand B
//     sel    out  4  ALU select code (sel[3] also feeds the display decoder)
//     valid  out  1  a, b and sel form a complete loaded set
//     stage  out  2  current state encoding, for the LEDs
//
//   Build option:
//     OPERAND_LOADER_SYNC_EN - when defined, btn and sw each pass through a
//     2-flop synchronizer (reset to 0) before use, adding 2 cycles of press
//     latency. When undefined, btn/sw are used directly and must already be
//     synchronous to clk.
//
//   The button is accepted after its level has differed from the stable level
//   for DEBOUNCE_CYCLES consecutive samples; only the 0->1 acceptance produces
//   a one-cycle press pulse, and the state machine acts on that pulse.

module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] sel,
  output logic       valid,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {
    LOAD_A   = 2'd0,
    LOAD_B   = 2'd1,
    LOAD_SEL = 2'd2,
    RUN      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Sampled inputs seen by the debouncer and the load path.
  logic       btn_s;
  logic [3:0] sw_s;

`ifdef OPERAND_LOADER_SYNC_EN
  logic       btn_meta_q, btn_sync_q;
  logic [3:0] sw_meta_q,  sw_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  assign btn_s = btn_sync_q;
  assign sw_s  = sw_sync_q;
`else
  assign btn_s = btn;
  assign sw_s  = sw;
`endif

  // Debouncer state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;

  // Load state machine
  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  // The counter runs only while the sampled level disagrees with the stable
  // level; any agreeing sample restarts it, so a glitch shorter than
  // DEBOUNCE_CYCLES never reaches CNT_MAX. The pulse is raised on the same
  // edge the stable level rises, so it appears one cycle later as a register.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    if (btn_s != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = btn_s;
        pulse_d  = btn_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (pulse_q) begin
      unique case (state_q)
        LOAD_A: begin
          a_d     = sw_s;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = sw_s;
          state_d = LOAD_SEL;
        end
        LOAD_SEL: begin
          sel_d   = sw_s;
          valid_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign stage = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader with DEBOUNCE_CYCLES=4. Directed scenarios check
// fixed expected values; a reference model (sample-window debounce, abstract
// load sequence) is compared against the outputs every cycle, including a
// randomized phase with random button runs, switch values and resets.
// Build with OPERAND_LOADER_SYNC_EN defined to check the synchronized variant.

module tb_operand_loader;

  localparam int D = 4;
`ifdef OPERAND_LOADER_SYNC_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = D + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic       btn = 1'b0;
  logic [3:0] a, b, sel;
  logic       valid;
  logic [1:0] stage;

  int total = 0;
  int bad   = 0;

  operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .btn   (btn),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .valid (valid),
    .stage (stage)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         chk_en = 1'b0;
  bit         hist[$];
  bit         m_stable, m_pulse, m_valid, all_diff, sb;
  int         m_state;
  logic [3:0] m_a, m_b, m_sel, ssw;
`ifdef OPERAND_LOADER_SYNC_EN
  bit         mb1, mb2;
  logic [3:0] mw1, mw2;
`endif

  always @(posedge clk) begin
`ifdef OPERAND_LOADER_SYNC_EN
    sb  = mb2;
    ssw = mw2;
`else
    sb  = btn;
    ssw = sw;
`endif
    if (!rst_n) begin
      m_stable = 0; m_pulse = 0; m_valid = 0; m_state = 0;
      m_a = 0; m_b = 0; m_sel = 0;
      hist.delete();
      chk_en = 1'b1;
`ifdef OPERAND_LOADER_SYNC_EN
      mb1 = 0; mb2 = 0; mw1 = 0; mw2 = 0;
`endif
    end else begin
      if (m_pulse) begin
        case (m_state)
          0: m_a = ssw;
          1: m_b = ssw;
          2: begin m_sel = ssw; m_valid = 1; end
          default: m_valid = 0;
        endcase
        m_state = (m_state + 1) % 4;
      end
      // Accept a level once the last D samples all disagree with the stable level.
      hist.push_back(sb);
      if (hist.size() > D) void'(hist.pop_front());
      m_pulse = 0;
      if (hist.size() == D) begin
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
        if (all_diff) begin
          m_stable = !m_stable;
          m_pulse  = m_stable;
        end
      end
`ifdef OPERAND_LOADER_SYNC_EN
      mb2 = mb1; mb1 = btn;
      mw2 = mw1; mw1 = sw;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_a",     a,     m_a);
      check("m_b",     b,     m_b);
      check("m_sel",   sel,   m_sel);
      check("m_valid", valid, m_valid);
      check("m_stage", stage, m_state[1:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: measure edges from btn rising to the stage change, then release.
  task automatic press(input logic [3:0] v);
    logic [1:0] old;
    int n;
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    old = stage;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (stage == old && n < 30);
    check("press_lat", n, LAT);
    @(negedge clk);
    btn = 1'b0;
    idle(LAT + 2);
    sw = 4'($urandom);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int run;

  initial begin
    idle(2);
    rst_n = 1'b1;
    check("rst_a", a, 0);
    check("rst_valid", valid, 0);
    check("rst_stage", stage, 0);

    // Bounce shorter than the debounce window must be ignored.
    for (int t = 0; t < 20; ) begin
      btn = ~btn;
      run = $urandom_range(1, 3);
      idle(run);
      t += run;
    end
    btn = 1'b0;
    idle(LAT + 3);
    check("bounce_stage", stage, 0);
    check("bounce_a", a, 0);

    // Sequential load
    press(4'b0111);
    press(4'b1010);
    press(4'b0011);
    check("seq_a", a, 4'b0111);
    check("seq_b", b, 4'b1010);
    check("seq_sel", sel, 4'b0011);
    check("seq_valid", valid, 1);
    check("seq_stage", stage, 3);

    // Rearm keeps old values
    press(4'b0000);
    check("rearm_valid", valid, 0);
    check("rearm_stage", stage, 0);
    check("rearm_a", a, 4'b0111);
    check("rearm_sel", sel, 4'b0011);
    press(4'b1111);
    check("rearm_newa", a, 4'b1111);
    check("rearm_b", b, 4'b1010);

    // Mid-sequence reset
    do_reset();
    press(4'b0101);
    press(4'b1100);
    check("mid_pre_stage", stage, 2);
    check("mid_pre_a", a, 4'b0101);
    do_reset();
    check("mid_a", a, 0);
    check("mid_b", b, 0);
    check("mid_sel", sel, 0);
    check("mid_valid", valid, 0);
    check("mid_stage", stage, 0);

    // Held button: exactly one transition
    sw  = 4'b1001;
    btn = 1'b1;
    idle(50);
    check("held_stage", stage, 1);
    check("held_a", a, 4'b1001);
    btn = 1'b0;
    idle(LAT + 2);
    press(4'b0110);
    check("repress_stage", stage, 2);
    check("repress_b", b, 4'b0110);

    // Button held through reset counts as a new press after reset.
    @(negedge clk);
    btn = 1'b1;
    sw  = 4'b1110;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 2);
    check("thru_rst_stage", stage, 1);
    check("thru_rst_a", a, 4'b1110);
    btn = 1'b0;
    idle(LAT + 2);

    // Randomized phase against the model
    repeat (600) begin
      btn = 1'($urandom);
      run = $urandom_range(1, 2 * D);
      repeat (run) begin
        @(negedge clk);
        sw    = 4'($urandom);
        rst_n = ($urandom_range(0, 199) != 0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    btn   = 1'b0;
    idle(LAT + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
